// File: rtl/cbc_tdes_pkg.sv
// Shared constants, FSM state type and DES permutation/S-box tables for cbc_tdes.
// Bit vectors keep FIPS bit 1 in the MSB, so FIPS position p maps to vector index (width - p).
package cbc_tdes_pkg;

   localparam int BLOCK_W = 64;
   localparam int ROUNDS  = 16;
   localparam int LATENCY = 49;

   typedef enum logic [2:0] {IDLE, P1, P2, P3, OUT} state_t;

   localparam int unsigned SHIFT_L [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
   // Decrypt walks the schedule backwards: first subkey is K16 = PC2(C0D0), hence the leading 0.
   localparam int unsigned SHIFT_R [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

   localparam int unsigned IP_T [64] = '{
      58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
      62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
      57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
      61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};

   localparam int unsigned FP_T [64] = '{
      40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
      38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
      36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
      34,2,42,10,50,18,58,26, 33,1,41, 9,49,17,57,25};

   localparam int unsigned E_T [48] = '{
      32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9,10,11,
      12,13,12,13,14,15,16,17,16,17,18,19,20,21,20,21,
      22,23,24,25,24,25,26,27,28,29,28,29,30,31,32, 1};

   localparam int unsigned P_T [32] = '{
      16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
       2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};

   localparam int unsigned PC1_T [56] = '{
      57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
      10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
      63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
      14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};

   localparam int unsigned PC2_T [48] = '{
      14,17,11,24, 1, 5, 3,28,15, 6,21,10,
      23,19,12, 4,26, 8,16, 7,27,20,13, 2,
      41,52,31,37,47,55,30,40,51,45,33,48,
      44,49,39,56,34,53,46,42,50,36,29,32};

   // Eight boxes of 64 entries each, laid out row-major (row*16 + column).
   localparam logic [3:0] SBOX [512] = '{
      14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
      15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
      10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
      7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
      2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
      12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
      4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
      13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

   function automatic logic [63:0] ip_perm(input logic [63:0] x);
      logic [63:0] y;
      for (int j = 0; j < 64; j++) y[63-j] = x[64-IP_T[j]];
      return y;
   endfunction

   function automatic logic [63:0] fp_perm(input logic [63:0] x);
      logic [63:0] y;
      for (int j = 0; j < 64; j++) y[63-j] = x[64-FP_T[j]];
      return y;
   endfunction

   function automatic logic [47:0] e_perm(input logic [31:0] x);
      logic [47:0] y;
      for (int j = 0; j < 48; j++) y[47-j] = x[32-E_T[j]];
      return y;
   endfunction

   function automatic logic [31:0] p_perm(input logic [31:0] x);
      logic [31:0] y;
      for (int j = 0; j < 32; j++) y[31-j] = x[32-P_T[j]];
      return y;
   endfunction

   function automatic logic [55:0] pc1_perm(input logic [63:0] x);
      logic [55:0] y;
      for (int j = 0; j < 56; j++) y[55-j] = x[64-PC1_T[j]];
      return y;
   endfunction

   function automatic logic [47:0] pc2_perm(input logic [55:0] x);
      logic [47:0] y;
      for (int j = 0; j < 48; j++) y[47-j] = x[56-PC2_T[j]];
      return y;
   endfunction

   function automatic logic [31:0] sbox_sub(input logic [47:0] x);
      logic [31:0] y;
      logic [5:0]  six;
      for (int b = 0; b < 8; b++) begin
         six = x[47-6*b -: 6];
         y[31-4*b -: 4] = SBOX[b*64 + int'({six[5], six[0], six[4:1]})];
      end
      return y;
   endfunction

   function automatic logic [27:0] rot28(input logic [27:0] x, input int unsigned amt,
                                         input logic right);
      logic [27:0] y;
      y = x;
      if (right) begin
         if (amt == 1) y = {x[0], x[27:1]};
         else if (amt == 2) y = {x[1:0], x[27:2]};
      end else begin
         if (amt == 1) y = {x[26:0], x[27]};
         else if (amt == 2) y = {x[25:0], x[27:26]};
      end
      return y;
   endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round; the last round of a pass skips the L/R swap.
module des_round
   import cbc_tdes_pkg::*;
(
   input  logic [31:0] left,
   input  logic [31:0] right,
   input  logic [47:0] subkey,
   input  logic        last_round,
   output logic [31:0] next_left,
   output logic [31:0] next_right
);

   logic [31:0] f_out;

   // Leaving round 16 unswapped makes {L,R} equal IP of the pass output, so passes chain with no FP/IP.
   always_comb begin
      f_out = p_perm(sbox_sub(e_perm(right) ^ subkey));
      if (last_round) begin
         next_left  = left ^ f_out;
         next_right = right;
      end else begin
         next_left  = right;
         next_right = left ^ f_out;
      end
   end

endmodule

// File: rtl/cbc_tdes.sv
// Triple-DES EDE in CBC mode, one round per clock, three passes back-to-back per block.
module cbc_tdes
   import cbc_tdes_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start_i,
   input  logic               mode_i,
   input  logic [BLOCK_W-1:0] key1_i,
   input  logic [BLOCK_W-1:0] key2_i,
   input  logic [BLOCK_W-1:0] key3_i,
   input  logic [BLOCK_W-1:0] iv_i,
   input  logic [BLOCK_W-1:0] data_i,
   input  logic               valid_i,
   output logic [BLOCK_W-1:0] data_o,
   output logic               valid_o,
   output logic               ready_o
);

   state_t             state;
   logic [3:0]         round;
   logic [31:0]        l_reg, r_reg, l_next, r_next;
   logic [27:0]        c_reg, d_reg, c_next, d_next;
   logic [BLOCK_W-1:0] key_p2, key_p3, chain, cv_reg, in_reg, cv_sel, result;
   logic               mode_reg, pass_dec, last_round;
   logic [47:0]        subkey;
   logic [31:0]        shift_amt;

   // The middle pass runs in the opposite direction to the outer two.
   always_comb begin
      pass_dec   = mode_reg ^ (state == P2);
      shift_amt  = pass_dec ? SHIFT_R[round] : SHIFT_L[round];
      c_next     = rot28(c_reg, shift_amt, pass_dec);
      d_next     = rot28(d_reg, shift_amt, pass_dec);
      subkey     = pc2_perm({c_next, d_next});
      last_round = (round == 4'(ROUNDS - 1));
      cv_sel     = start_i ? iv_i : chain;
      result     = fp_perm({l_reg, r_reg});
   end

   des_round u_round (
      .left       (l_reg),
      .right      (r_reg),
      .subkey     (subkey),
      .last_round (last_round),
      .next_left  (l_next),
      .next_right (r_next)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         round    <= '0;
         l_reg    <= '0;
         r_reg    <= '0;
         c_reg    <= '0;
         d_reg    <= '0;
         key_p2   <= '0;
         key_p3   <= '0;
         chain    <= '0;
         cv_reg   <= '0;
         in_reg   <= '0;
         mode_reg <= 1'b0;
         data_o   <= '0;
         valid_o  <= 1'b0;
         ready_o  <= 1'b1;
      end else begin
         valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_i && ready_o) begin
                  // Decrypt runs the keys in reverse order: D_k3, E_k2, D_k1.
                  mode_reg       <= mode_i;
                  key_p2         <= key2_i;
                  key_p3         <= mode_i ? key1_i : key3_i;
                  {c_reg, d_reg} <= pc1_perm(mode_i ? key3_i : key1_i);
                  {l_reg, r_reg} <= ip_perm(mode_i ? data_i : (data_i ^ cv_sel));
                  cv_reg         <= cv_sel;
                  in_reg         <= data_i;
                  round          <= '0;
                  ready_o        <= 1'b0;
                  state          <= P1;
               end
            end
            P1, P2, P3: begin
               l_reg <= l_next;
               r_reg <= r_next;
               if (last_round) begin
                  round <= '0;
                  if (state == P1) begin
                     {c_reg, d_reg} <= pc1_perm(key_p2);
                     state          <= P2;
                  end else if (state == P2) begin
                     {c_reg, d_reg} <= pc1_perm(key_p3);
                     state          <= P3;
                  end else begin
                     state <= OUT;
                  end
               end else begin
                  round <= round + 4'd1;
                  c_reg <= c_next;
                  d_reg <= d_next;
               end
            end
            OUT: begin
               data_o  <= mode_reg ? (result ^ cv_reg) : result;
               chain   <= mode_reg ? in_reg : result;
               valid_o <= 1'b1;
               ready_o <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cbc_tdes.sv
// Directed self-checking bench for cbc_tdes using known DES/TDES vectors and CBC round trips.
module tb_cbc_tdes;
   import cbc_tdes_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_i, mode_i, valid_i;
   logic [63:0] key1_i, key2_i, key3_i, iv_i, data_i;
   logic [63:0] data_o;
   logic        valid_o, ready_o;

   int checks = 0;
   int errors = 0;

   logic [63:0] res;
   int          lat;
   int          pulses;
   logic [63:0] pt [19];
   logic [63:0] ct [19];

   localparam logic [63:0] K0101 = 64'h0101010101010101;
   localparam logic [63:0] K1334 = 64'h133457799BBCDFF1;

   cbc_tdes dut (
      .clk     (clk),
      .reset   (reset),
      .start_i (start_i),
      .mode_i  (mode_i),
      .key1_i  (key1_i),
      .key2_i  (key2_i),
      .key3_i  (key3_i),
      .iv_i    (iv_i),
      .data_i  (data_i),
      .valid_i (valid_i),
      .data_o  (data_o),
      .valid_o (valid_o),
      .ready_o (ready_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the accept edge.
   task automatic apply_stimulus(input logic mode, input logic start, input logic [63:0] k1,
                                 input logic [63:0] k2, input logic [63:0] k3,
                                 input logic [63:0] iv, input logic [63:0] data);
      int n = 0;
      while (!ready_o && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!ready_o) check_output("ready_timeout", {63'b0, ready_o}, 64'd1);
      mode_i  = mode;
      start_i = start;
      key1_i  = k1;
      key2_i  = k2;
      key3_i  = k3;
      iv_i    = iv;
      data_i  = data;
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic wait_result(output logic [63:0] r, output int edges);
      edges = 0;
      do begin
         @(posedge clk);
         #1;
         edges++;
      end while (!valid_o && edges < 200);
      check_output("valid_seen", {63'b0, valid_o}, 64'd1);
      r = data_o;
   endtask

   task automatic count_valid(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (valid_o) n++;
      end
   endtask

   initial begin
      reset   = 1'b0;
      start_i = 1'b0;
      mode_i  = 1'b0;
      valid_i = 1'b0;
      key1_i  = '0;
      key2_i  = '0;
      key3_i  = '0;
      iv_i    = '0;
      data_i  = '0;
      repeat (3) @(posedge clk);
      #1;
      check_output("rst_valid", {63'b0, valid_o}, 64'd0);
      check_output("rst_data", data_o, 64'd0);
      check_output("rst_ready", {63'b0, ready_o}, 64'd1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] single-DES known answer, latency and handshake");
      apply_stimulus(1'b0, 1'b1, K0101, K0101, K0101, 64'h0, 64'h8000000000000000);
      check_output("ready_drop", {63'b0, ready_o}, 64'd0);
      wait_result(res, lat);
      check_output("kat_8000", res, 64'h95F8A5E5DD31D900);
      check_output("latency", 64'(lat), 64'(LATENCY));
      check_output("ready_with_valid", {63'b0, ready_o}, 64'd1);
      @(posedge clk);
      #1;
      check_output("valid_one_cycle", {63'b0, valid_o}, 64'd0);
      check_output("data_hold", data_o, 64'h95F8A5E5DD31D900);

      $display("[TB] CBC input XOR from iv");
      apply_stimulus(1'b0, 1'b1, K0101, K0101, K0101, 64'h8000000000000000, 64'h0);
      wait_result(res, lat);
      check_output("cbc_iv_xor", res, 64'h95F8A5E5DD31D900);

      $display("[TB] classic vector encrypt and decrypt");
      apply_stimulus(1'b0, 1'b1, K1334, K1334, K1334, 64'h0, 64'h0123456789ABCDEF);
      wait_result(res, lat);
      check_output("enc_classic", res, 64'h85E813540F0AB405);
      apply_stimulus(1'b1, 1'b1, K1334, K1334, K1334, 64'h0, 64'h85E813540F0AB405);
      wait_result(res, lat);
      check_output("dec_classic", res, 64'h0123456789ABCDEF);

      $display("[TB] valid_i while busy is dropped");
      apply_stimulus(1'b0, 1'b1, K0101, K0101, K0101, 64'h0, 64'h8000000000000000);
      repeat (10) @(posedge clk);
      #1;
      valid_i = 1'b1;
      start_i = 1'b1;
      iv_i    = 64'hDEADBEEFCAFEF00D;
      data_i  = 64'h1234123412341234;
      repeat (3) @(posedge clk);
      #1;
      valid_i = 1'b0;
      wait_result(res, lat);
      check_output("busy_result", res, 64'h95F8A5E5DD31D900);
      count_valid(60, pulses);
      check_output("busy_no_extra_valid", 64'(pulses), 64'd0);
      apply_stimulus(1'b1, 1'b0, K0101, K0101, K0101, 64'h0, 64'h95F8A5E5DD31D900);
      wait_result(res, lat);
      check_output("busy_chain_kept", res, 64'h15F8A5E5DD31D900);

      $display("[TB] reset mid-operation");
      apply_stimulus(1'b0, 1'b1, K1334, K1334, K1334, 64'h0, 64'h0123456789ABCDEF);
      repeat (20) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_output("midrst_valid", {63'b0, valid_o}, 64'd0);
      check_output("midrst_data", data_o, 64'd0);
      check_output("midrst_ready", {63'b0, ready_o}, 64'd1);
      @(negedge clk);
      reset = 1'b1;
      count_valid(60, pulses);
      check_output("midrst_aborted", 64'(pulses), 64'd0);
      apply_stimulus(1'b0, 1'b0, K0101, K0101, K0101, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000);
      wait_result(res, lat);
      check_output("midrst_chain_zero", res, 64'h95F8A5E5DD31D900);

      $display("[TB] three-key CBC round trip");
      for (int i = 0; i < 19; i++)
         pt[i] = 64'h0011223344556677 * 64'(i + 1) ^ 64'hA5A5000000005A5A;
      for (int i = 0; i < 19; i++) begin
         apply_stimulus(1'b0, i == 0, 64'h1111111111111111, 64'h5555555555555555,
                        64'h9999999999999999, 64'h0, pt[i]);
         wait_result(ct[i], lat);
      end
      for (int i = 0; i < 19; i++) begin
         apply_stimulus(1'b1, i == 0, 64'h1111111111111111, 64'h5555555555555555,
                        64'h9999999999999999, 64'h0, ct[i]);
         wait_result(res, lat);
         check_output($sformatf("roundtrip_%0d", i), res, pt[i]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
